// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_sync
// Brief    : SPI slave with the SPI pins oversampled into the clk domain.
//            All four CPOL/CPHA modes, configurable word width and bit order,
//            one-word TX holding buffer, valid/ready RX and TX handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_sync #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int         c_cnt_w    = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic       c_sclk_idle = (CPOL != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_cnt_w-1:0]     r_bit_cnt;
    logic [DATA_W-1:0]      r_shift_rx;
    logic [DATA_W-1:0]      r_shift_tx;
    logic [DATA_W-1:0]      r_hold;
    logic                   r_hold_full;

    logic w_sclk, w_cs, w_mosi;
    logic w_sclk_rise, w_sclk_fall, w_lead, w_trail;
    logic w_sample, w_shift, w_cs_fall, w_cs_rise;
    logic w_word_done, w_shift_ok;
    logic [DATA_W-1:0] w_rx_nxt;
    logic [DATA_W-1:0] w_tx_adv;
    logic              w_tx_cur_bit, w_tx_adv_bit, w_hold_first_bit;

    // Pin synchronisers plus one-cycle-delayed copies for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= {SYNC_STAGES{c_sclk_idle}};
            r_cs_sync   <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= '0;
            r_sclk_d    <= c_sclk_idle;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_lead      = (CPOL != 0) ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = (CPOL != 0) ? w_sclk_rise : w_sclk_fall;
    assign w_sample    = (CPHA != 0) ? w_trail : w_lead;
    assign w_shift     = (CPHA != 0) ? w_lead  : w_trail;

    // With CPHA=0 bit 0 is already on MISO after LOAD, so the shift edge
    // trailing the previous word's last sample must not advance the word.
    assign w_shift_ok  = w_shift && ((CPHA != 0) || (r_bit_cnt != '0));

    assign w_word_done = (r_state == S_SHIFT) && w_sample &&
                         (r_bit_cnt == c_cnt_last) && !w_cs_rise;

    assign w_rx_nxt = (MSB_FIRST != 0) ? {r_shift_rx[DATA_W-2:0], w_mosi}
                                       : {w_mosi, r_shift_rx[DATA_W-1:1]};
    assign w_tx_adv = (MSB_FIRST != 0) ? {r_shift_tx[DATA_W-2:0], 1'b0}
                                       : {1'b0, r_shift_tx[DATA_W-1:1]};
    assign w_tx_cur_bit     = (MSB_FIRST != 0) ? r_shift_tx[DATA_W-1] : r_shift_tx[0];
    assign w_tx_adv_bit     = (MSB_FIRST != 0) ? w_tx_adv[DATA_W-1]   : w_tx_adv[0];
    assign w_hold_first_bit = (MSB_FIRST != 0) ? r_hold[DATA_W-1]     : r_hold[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; a chip-select release always wins
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cs_fall) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_word_done) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_cs_rise) w_state_nxt = S_IDLE;
    end

    // Datapath: holding buffer, shift registers, handshakes and MISO drive
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_shift_rx  <= '0;
            r_shift_tx  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;

            if (rx_valid && rx_ready) rx_valid <= 1'b0;

            // Accept and LOAD-consume are mutually exclusive on hold_full
            if (tx_valid && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end

            if (w_cs_rise) begin
                spi_miso_oe <= 1'b0;
                spi_miso    <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (r_hold_full) begin
                            r_shift_tx  <= r_hold;
                            r_hold_full <= 1'b0;
                        end else begin
                            r_shift_tx  <= '0;
                            tx_underrun <= 1'b1;
                        end
                        r_bit_cnt   <= '0;
                        r_shift_rx  <= '0;
                        spi_miso_oe <= 1'b1;
                        if (CPHA == 0) spi_miso <= r_hold_full & w_hold_first_bit;
                    end
                    S_SHIFT: begin
                        if (w_sample) begin
                            r_shift_rx <= w_rx_nxt;
                            r_bit_cnt  <= r_bit_cnt + c_cnt_one;
                            if (r_bit_cnt == c_cnt_last) begin
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= w_rx_nxt;
                                    rx_valid <= 1'b1;
                                end else begin
                                    rx_overrun <= 1'b1;
                                end
                            end
                        end
                        if (w_shift_ok) begin
                            r_shift_tx <= w_tx_adv;
                            spi_miso   <= (CPHA != 0) ? w_tx_cur_bit : w_tx_adv_bit;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_ready = ~r_hold_full;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_slave_sync
// Brief    : Bench for spi_slave_sync. Instance A runs mode 0 MSB-first,
//            instance B runs mode 3 LSB-first. A bit-banging host drives
//            random words; expectations come from what the host sent and
//            what was offered on the TX port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_sync;

    localparam int HALF = 8;   // clk cycles per sclk half period

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       sclk_a, cs_n_a, mosi_a, miso_a, oe_a, rx_valid_a, rx_ready_a;
    logic       rx_overrun_a, tx_valid_a, tx_ready_a, tx_underrun_a, busy_a;
    logic [7:0] rx_data_a, tx_data_a;
    logic       sclk_b, cs_n_b, mosi_b, miso_b, oe_b, rx_valid_b, rx_ready_b;
    logic       rx_overrun_b, tx_valid_b, tx_ready_b, tx_underrun_b, busy_b;
    logic [7:0] rx_data_b, tx_data_b;

    spi_slave_sync #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .rst(rst), .spi_sclk(sclk_a), .spi_cs_n(cs_n_a), .spi_mosi(mosi_a),
        .spi_miso(miso_a), .spi_miso_oe(oe_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .rx_overrun(rx_overrun_a), .tx_data(tx_data_a),
        .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_underrun(tx_underrun_a), .busy(busy_a));

    spi_slave_sync #(.DATA_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .rst(rst), .spi_sclk(sclk_b), .spi_cs_n(cs_n_b), .spi_mosi(mosi_b),
        .spi_miso(miso_b), .spi_miso_oe(oe_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .rx_overrun(rx_overrun_b), .tx_data(tx_data_b),
        .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_underrun(tx_underrun_b), .busy(busy_b));

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard state: pulse counters, accepted-word queues, latency stamps
    int         cyc = 0;
    int         ovr_a = 0, und_a = 0, ovr_b = 0, und_b = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic       rv_prev_a = 1'b0;
    int         rv_rise_cyc_a = 0;
    int         last_rise_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (rx_overrun_a)  ovr_a <= ovr_a + 1;
            if (tx_underrun_a) und_a <= und_a + 1;
            if (rx_overrun_b)  ovr_b <= ovr_b + 1;
            if (tx_underrun_b) und_b <= und_b + 1;
            if (rx_valid_a && rx_ready_a) q_a.push_back(rx_data_a);
            if (rx_valid_b && rx_ready_b) q_b.push_back(rx_data_b);
        end
    end

    always @(negedge clk) begin
        rv_prev_a <= rx_valid_a;
        if (rx_valid_a && !rv_prev_a) rv_rise_cyc_a <= cyc;
    end

    // Host: shift nbits of tx out on MOSI, collect MISO just before each sample edge
    task automatic spi_bits(input int which, input logic [7:0] tx, input int nbits,
                            output logic [7:0] rd);
        int k;
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            k = (which == 0) ? 7 - i : i;
            if (which == 1) sclk_b = 1'b0;
            if (which == 0) mosi_a = tx[k]; else mosi_b = tx[k];
            repeat (HALF) @(negedge clk);
            rd[k] = (which == 0) ? miso_a : miso_b;
            last_rise_cyc = cyc;
            if (which == 0) sclk_a = 1'b1; else sclk_b = 1'b1;
            repeat (HALF) @(negedge clk);
            if (which == 0) sclk_a = 1'b0;
        end
    endtask

    task automatic cs_set(input int which, input logic v);
        if (which == 0) cs_n_a = v; else cs_n_b = v;
        repeat (HALF) @(negedge clk);
    endtask

    // Offer one TX word; a missing tx_ready within the budget is a failure
    task automatic push_tx(input int which, input logic [7:0] d);
        int n;
        n = 0;
        if (which == 0) begin tx_data_a = d; tx_valid_a = 1'b1; end
        else            begin tx_data_b = d; tx_valid_b = 1'b1; end
        while (((which == 0) ? tx_ready_a : tx_ready_b) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n >= 200) $display("FAIL push_tx_timeout: tx_ready got 0 want 1 within 200 cycles");
        else n_pass++;
        @(negedge clk);
        if (which == 0) tx_valid_a = 1'b0; else tx_valid_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        n_total++; if (miso_a !== 1'b0)      $display("FAIL reset_miso: got %b want 0", miso_a); else n_pass++;
        n_total++; if (oe_a !== 1'b0)        $display("FAIL reset_oe: got %b want 0", oe_a); else n_pass++;
        n_total++; if (rx_data_a !== 8'h00)  $display("FAIL reset_rx_data: got %h want 00", rx_data_a); else n_pass++;
        n_total++; if (rx_valid_a !== 1'b0)  $display("FAIL reset_rx_valid: got %b want 0", rx_valid_a); else n_pass++;
        n_total++; if (rx_overrun_a !== 1'b0) $display("FAIL reset_overrun: got %b want 0", rx_overrun_a); else n_pass++;
        n_total++; if (tx_underrun_a !== 1'b0) $display("FAIL reset_underrun: got %b want 0", tx_underrun_a); else n_pass++;
        n_total++; if (busy_a !== 1'b0)      $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
        n_total++; if (tx_ready_a !== 1'b1)  $display("FAIL reset_tx_ready: got %b want 1", tx_ready_a); else n_pass++;
        n_total++; if (oe_b !== 1'b0)        $display("FAIL reset_oe_b: got %b want 0", oe_b); else n_pass++;
        n_total++; if (tx_ready_b !== 1'b1)  $display("FAIL reset_tx_ready_b: got %b want 1", tx_ready_b); else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    // Mode 0 single-word frames with the hold buffer preloaded
    task automatic test_mode0();
        logic [7:0] h, t, rd;
        int ub;
        for (int it = 0; it < 4; it++) begin
            h = (it == 0) ? 8'hA5 : 8'($urandom);
            t = (it == 0) ? 8'h3C : 8'($urandom);
            rx_ready_a = 1'b0;
            push_tx(0, t);
            ub = und_a;
            cs_set(0, 1'b0);
            n_total++; if (oe_a !== 1'b1)  $display("FAIL m0_oe_active: got %b want 1", oe_a); else n_pass++;
            n_total++; if (busy_a !== 1'b1) $display("FAIL m0_busy: got %b want 1", busy_a); else n_pass++;
            n_total++; if (und_a !== ub)   $display("FAIL m0_no_underrun: got %0d want %0d", und_a, ub); else n_pass++;
            spi_bits(0, h, 8, rd);
            cs_set(0, 1'b1);
            n_total++; if (rx_valid_a !== 1'b1) $display("FAIL m0_rx_valid: got %b want 1", rx_valid_a); else n_pass++;
            n_total++; if (rx_data_a !== h)     $display("FAIL m0_rx_data: got %h want %h", rx_data_a, h); else n_pass++;
            n_total++; if (rd !== t)            $display("FAIL m0_miso_word: got %h want %h", rd, t); else n_pass++;
            n_total++; if (rv_rise_cyc_a - last_rise_cyc !== 3)
                $display("FAIL m0_latency: got %0d want 3", rv_rise_cyc_a - last_rise_cyc); else n_pass++;
            n_total++; if (oe_a !== 1'b0)  $display("FAIL m0_oe_idle: got %b want 0", oe_a); else n_pass++;
            n_total++; if (busy_a !== 1'b0) $display("FAIL m0_idle: got %b want 0", busy_a); else n_pass++;
            rx_ready_a = 1'b1;
            @(negedge clk);
            n_total++; if (rx_valid_a !== 1'b0) $display("FAIL m0_rx_consume: got %b want 0", rx_valid_a); else n_pass++;
        end
    endtask

    // Mode 3 LSB-first, two words per frame with cs_n held low
    task automatic test_mode3_b2b();
        logic [7:0] h1, h2, t1, t2, r1, r2;
        int base, ob, ub;
        rx_ready_b = 1'b1;
        for (int it = 0; it < 2; it++) begin
            h1 = (it == 0) ? 8'h81 : 8'($urandom);
            h2 = (it == 0) ? 8'h7E : 8'($urandom);
            t1 = 8'($urandom);
            t2 = 8'($urandom);
            base = q_b.size(); ob = ovr_b; ub = und_b;
            push_tx(1, t1);
            cs_set(1, 1'b0);
            push_tx(1, t2);
            spi_bits(1, h1, 8, r1);
            spi_bits(1, h2, 8, r2);
            cs_set(1, 1'b1);
            n_total++; if (q_b.size() !== base + 2)
                $display("FAIL m3_word_count: got %0d want %0d", q_b.size() - base, 2); else n_pass++;
            n_total++; if (q_b.size() < base + 1 || q_b[base] !== h1)
                $display("FAIL m3_word0: got %h want %h", (q_b.size() > base) ? q_b[base] : 8'hxx, h1); else n_pass++;
            n_total++; if (q_b.size() < base + 2 || q_b[base+1] !== h2)
                $display("FAIL m3_word1: got %h want %h", (q_b.size() > base + 1) ? q_b[base+1] : 8'hxx, h2); else n_pass++;
            n_total++; if (r1 !== t1) $display("FAIL m3_miso0: got %h want %h", r1, t1); else n_pass++;
            n_total++; if (r2 !== t2) $display("FAIL m3_miso1: got %h want %h", r2, t2); else n_pass++;
            n_total++; if (ovr_b !== ob) $display("FAIL m3_overrun: got %0d want %0d", ovr_b - ob, 0); else n_pass++;
            // three loads per two-word frame, two words supplied
            n_total++; if (und_b !== ub + 1) $display("FAIL m3_underrun: got %0d want 1", und_b - ub); else n_pass++;
        end
    endtask

    // Two words arrive while the consumer is stalled
    task automatic test_overrun();
        logic [7:0] h1, h2, rd;
        int ob;
        h1 = 8'($urandom); h2 = 8'($urandom);
        rx_ready_a = 1'b0;
        ob = ovr_a;
        cs_set(0, 1'b0);
        spi_bits(0, h1, 8, rd);
        spi_bits(0, h2, 8, rd);
        cs_set(0, 1'b1);
        n_total++; if (rx_data_a !== h1)    $display("FAIL ovr_rx_data: got %h want %h", rx_data_a, h1); else n_pass++;
        n_total++; if (rx_valid_a !== 1'b1) $display("FAIL ovr_rx_valid: got %b want 1", rx_valid_a); else n_pass++;
        n_total++; if (ovr_a !== ob + 1)    $display("FAIL ovr_pulses: got %0d want 1", ovr_a - ob); else n_pass++;
        rx_ready_a = 1'b1;
        @(negedge clk);
        n_total++; if (rx_valid_a !== 1'b0) $display("FAIL ovr_consume: got %b want 0", rx_valid_a); else n_pass++;
        n_total++; if (q_a.size() == 0 || q_a[q_a.size()-1] !== h1)
            $display("FAIL ovr_accepted: got %h want %h", (q_a.size() > 0) ? q_a[q_a.size()-1] : 8'hxx, h1); else n_pass++;
    endtask

    // Empty hold at frame start sends zeros; a later word goes out next frame
    task automatic test_underrun();
        logic [7:0] h, rd;
        int ub;
        h = 8'($urandom);
        ub = und_a;
        cs_set(0, 1'b0);
        n_total++; if (und_a !== ub + 1) $display("FAIL und_pulse: got %0d want 1", und_a - ub); else n_pass++;
        spi_bits(0, h, 8, rd);
        cs_set(0, 1'b1);
        n_total++; if (rd !== 8'h00) $display("FAIL und_miso_zero: got %h want 00", rd); else n_pass++;
        n_total++; if (q_a.size() == 0 || q_a[q_a.size()-1] !== h)
            $display("FAIL und_rx: got %h want %h", (q_a.size() > 0) ? q_a[q_a.size()-1] : 8'hxx, h); else n_pass++;
        push_tx(0, 8'h55);
        h = 8'($urandom);
        ub = und_a;
        cs_set(0, 1'b0);
        n_total++; if (und_a !== ub) $display("FAIL und_none: got %0d want 0", und_a - ub); else n_pass++;
        spi_bits(0, h, 8, rd);
        cs_set(0, 1'b1);
        n_total++; if (rd !== 8'h55) $display("FAIL und_next_word: got %h want 55", rd); else n_pass++;
    endtask

    // cs_n released after 5 bits; hold written mid-frame must survive the abort
    task automatic test_abort();
        logic [7:0] x, rd;
        int base, ob;
        x = 8'($urandom);
        base = q_a.size(); ob = ovr_a;
        cs_set(0, 1'b0);
        push_tx(0, x);
        spi_bits(0, 8'($urandom), 5, rd);
        cs_set(0, 1'b1);
        n_total++; if (q_a.size() !== base) $display("FAIL abort_no_word: got %0d want 0", q_a.size() - base); else n_pass++;
        n_total++; if (rx_valid_a !== 1'b0) $display("FAIL abort_rx_valid: got %b want 0", rx_valid_a); else n_pass++;
        n_total++; if (oe_a !== 1'b0)       $display("FAIL abort_oe: got %b want 0", oe_a); else n_pass++;
        n_total++; if (miso_a !== 1'b0)     $display("FAIL abort_miso: got %b want 0", miso_a); else n_pass++;
        n_total++; if (tx_ready_a !== 1'b0) $display("FAIL abort_hold_kept: got %b want 0", tx_ready_a); else n_pass++;
        n_total++; if (ovr_a !== ob)        $display("FAIL abort_overrun: got %0d want 0", ovr_a - ob); else n_pass++;
        cs_set(0, 1'b0);
        spi_bits(0, 8'hC3, 8, rd);
        cs_set(0, 1'b1);
        n_total++; if (q_a.size() < base + 1 || q_a[base] !== 8'hC3)
            $display("FAIL abort_next_rx: got %h want c3", (q_a.size() > base) ? q_a[base] : 8'hxx); else n_pass++;
        n_total++; if (rd !== x) $display("FAIL abort_next_miso: got %h want %h", rd, x); else n_pass++;
    endtask

    // rst pulsed mid-word with rx_valid set and the hold buffer full
    task automatic test_reset_mid();
        logic [7:0] rd;
        rx_ready_a = 1'b0;
        cs_set(0, 1'b0);
        spi_bits(0, 8'($urandom) | 8'h01, 8, rd);
        push_tx(0, 8'($urandom));
        spi_bits(0, 8'($urandom), 3, rd);
        n_total++; if (rx_valid_a !== 1'b1 || tx_ready_a !== 1'b0 || oe_a !== 1'b1)
            $display("FAIL rmid_pre: got valid=%b ready=%b oe=%b want 1 0 1", rx_valid_a, tx_ready_a, oe_a); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (miso_a !== 1'b0)      $display("FAIL rmid_miso: got %b want 0", miso_a); else n_pass++;
        n_total++; if (oe_a !== 1'b0)        $display("FAIL rmid_oe: got %b want 0", oe_a); else n_pass++;
        n_total++; if (rx_data_a !== 8'h00)  $display("FAIL rmid_rx_data: got %h want 00", rx_data_a); else n_pass++;
        n_total++; if (rx_valid_a !== 1'b0)  $display("FAIL rmid_rx_valid: got %b want 0", rx_valid_a); else n_pass++;
        n_total++; if (busy_a !== 1'b0)      $display("FAIL rmid_busy: got %b want 0", busy_a); else n_pass++;
        n_total++; if (tx_ready_a !== 1'b1)  $display("FAIL rmid_tx_ready: got %b want 1", tx_ready_a); else n_pass++;
        n_total++; if (rx_overrun_a !== 1'b0 || tx_underrun_a !== 1'b0)
            $display("FAIL rmid_pulses: got ovr=%b und=%b want 0 0", rx_overrun_a, tx_underrun_a); else n_pass++;
        rst = 1'b0;
        cs_n_a = 1'b1;
        sclk_a = 1'b0;
        rx_ready_a = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        sclk_a = 1'b0; cs_n_a = 1'b1; mosi_a = 1'b0; rx_ready_a = 1'b0; tx_valid_a = 1'b0; tx_data_a = '0;
        sclk_b = 1'b1; cs_n_b = 1'b1; mosi_b = 1'b0; rx_ready_b = 1'b0; tx_valid_b = 1'b0; tx_data_b = '0;
        @(negedge clk);
        test_reset();
        test_mode0();
        test_mode3_b2b();
        test_overrun();
        test_underrun();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
